// File: rtl/config_load_sequencer.sv
// config_load_sequencer: turns one load request into chip reset, register select, start pulse,
// done wait with timeout/retry and an optional second pass. SEQ_LOAD_STATUS_COUNTER_EN adds LoadStatusCount.
module config_load_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES     = 200000,
  parameter int unsigned MAX_RETRY          = 2,
  parameter int unsigned RESET_PULSE_CYCLES = 16,
  parameter int unsigned SETTLE_CYCLES      = 8
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        LoadRequest,
  input  logic [1:0]  LoadMode,
  input  logic        ChipResetEnable,
  input  logic        Abort,
  input  logic        ParameterLoadDone,
  output logic        MicrorocReset,
  output logic        SlowControlOrReadScopeSelect,
  output logic        ParameterLoadStart,
  output logic        Busy,
  output logic        LoadDone,
  output logic        LoadError,
  output logic [1:0]  RetryCount,
  output logic [15:0] LoadStatusCount
);
  localparam int unsigned TW  = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int unsigned RPW = $clog2(RESET_PULSE_CYCLES) + 1;
  localparam int unsigned SW  = $clog2(SETTLE_CYCLES) + 1;
  localparam int unsigned RW  = $clog2(MAX_RETRY + 1) + 2;

  typedef enum logic [3:0] {
    S_IDLE, S_CHIP_RESET, S_SELECT, S_SETTLE, S_START,
    S_WAIT_DONE, S_NEXT, S_FINISH, S_ERROR
  } state_t;

  state_t         r_state, w_next;
  logic           r_sync1, r_sync2, r_sync3, r_done_edge;
  logic [1:0]     r_mode;
  logic           r_pass;
  logic           r_error;
  logic [RW-1:0]  r_retry;
  logic [RPW-1:0] r_rst_cnt;
  logic [SW-1:0]  r_set_cnt;
  logic [TW-1:0]  r_to_cnt;
  logic           w_timeout;
  logic           w_can_retry;
  logic           w_pass_sel;

  // Two-flop synchroniser; the registered edge lands 3 Clk cycles after the source rises.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_sync1     <= 1'b0;
      r_sync2     <= 1'b0;
      r_sync3     <= 1'b0;
      r_done_edge <= 1'b0;
    end else begin
      r_sync1     <= ParameterLoadDone;
      r_sync2     <= r_sync1;
      r_sync3     <= r_sync2;
      r_done_edge <= r_sync2 & ~r_sync3;
    end
  end

  assign w_timeout   = (r_state == S_WAIT_DONE) && (r_to_cnt <= TW'(1));
  assign w_can_retry = r_retry < RW'(MAX_RETRY);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:       if (LoadRequest) w_next = ChipResetEnable ? S_CHIP_RESET : S_SELECT;
      S_CHIP_RESET: if (r_rst_cnt == '0) w_next = S_SELECT;
      S_SELECT:     w_next = S_SETTLE;
      S_SETTLE:     if (r_set_cnt == '0) w_next = S_START;
      S_START:      w_next = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (r_done_edge)    w_next = S_NEXT;
        else if (w_timeout) w_next = w_can_retry ? S_START : S_ERROR;
      end
      S_NEXT:       w_next = (r_mode == 2'b10 && !r_pass) ? S_SELECT : S_FINISH;
      S_FINISH:     w_next = S_IDLE;
      S_ERROR:      w_next = S_IDLE;
      default:      w_next = S_IDLE;
    endcase
    if (Abort) w_next = S_IDLE;
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state   <= S_IDLE;
      r_mode    <= '0;
      r_pass    <= 1'b0;
      r_error   <= 1'b0;
      r_retry   <= '0;
      r_rst_cnt <= '0;
      r_set_cnt <= '0;
      r_to_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (!Abort) begin
        case (r_state)
          S_IDLE: if (LoadRequest) begin
            r_mode    <= (LoadMode == 2'b11) ? 2'b00 : LoadMode;
            r_error   <= 1'b0;
            r_retry   <= '0;
            r_pass    <= 1'b0;
            r_rst_cnt <= RPW'(RESET_PULSE_CYCLES - 1);
          end
          S_CHIP_RESET: if (r_rst_cnt != '0) r_rst_cnt <= r_rst_cnt - RPW'(1);
          S_SELECT:     r_set_cnt <= SW'(SETTLE_CYCLES - 1);
          S_SETTLE:     if (r_set_cnt != '0) r_set_cnt <= r_set_cnt - SW'(1);
          S_START:      r_to_cnt <= TW'(TIMEOUT_CYCLES);
          S_WAIT_DONE: begin
            if (r_to_cnt != '0) r_to_cnt <= r_to_cnt - TW'(1);
            if (!r_done_edge && w_timeout) begin
              if (w_can_retry) r_retry <= r_retry + RW'(1);
              else             r_error <= 1'b1;
            end
          end
          S_NEXT: if (r_mode == 2'b10 && !r_pass) begin
            r_pass  <= 1'b1;
            r_retry <= '0;
          end
          default: ;
        endcase
      end
    end
  end

  // Select holds its pass value from SELECT through NEXT and rests at slow control otherwise.
  always_comb begin
    w_pass_sel = r_pass ? 1'b0 : (r_mode != 2'b01);
    case (r_state)
      S_SELECT, S_SETTLE, S_START, S_WAIT_DONE, S_NEXT: SlowControlOrReadScopeSelect = w_pass_sel;
      default: SlowControlOrReadScopeSelect = 1'b1;
    endcase
  end

  assign MicrorocReset      = (r_state == S_CHIP_RESET);
  assign ParameterLoadStart = (r_state == S_START);
  assign Busy               = (r_state != S_IDLE);
  assign LoadDone           = (r_state == S_FINISH);
  assign LoadError          = r_error;
  assign RetryCount         = (r_retry > RW'(3)) ? 2'd3 : r_retry[1:0];

`ifdef SEQ_LOAD_STATUS_COUNTER_EN
  logic [15:0] r_status_cnt;
  always_ff @(posedge Clk) begin
    if (Reset) r_status_cnt <= '0;
    else if (LoadDone && r_status_cnt != '1) r_status_cnt <= r_status_cnt + 16'd1;
  end
  assign LoadStatusCount = r_status_cnt;
`else
  assign LoadStatusCount = '0;
`endif

endmodule

// File: tb/tb_config_load_sequencer.sv
// Bench for config_load_sequencer: table rows plus random loads against a timeline model,
// and hand sequences for abort and mid-chip-reset Reset.
module tb_config_load_sequencer;
  localparam int T  = 50;
  localparam int MR = 2;

  logic        Clk = 1'b0;
  logic        Reset, LoadRequest, ChipResetEnable, Abort, ParameterLoadDone;
  logic [1:0]  LoadMode;
  logic        MicrorocReset, SlowControlOrReadScopeSelect, ParameterLoadStart;
  logic        Busy, LoadDone, LoadError;
  logic [1:0]  RetryCount;
  logic [15:0] LoadStatusCount;

  int n_cmp  = 0;
  int n_fail = 0;

  config_load_sequencer #(
    .TIMEOUT_CYCLES(T), .MAX_RETRY(MR), .RESET_PULSE_CYCLES(16), .SETTLE_CYCLES(8)
  ) u_dut (
    .Clk(Clk), .Reset(Reset), .LoadRequest(LoadRequest), .LoadMode(LoadMode),
    .ChipResetEnable(ChipResetEnable), .Abort(Abort), .ParameterLoadDone(ParameterLoadDone),
    .MicrorocReset(MicrorocReset), .SlowControlOrReadScopeSelect(SlowControlOrReadScopeSelect),
    .ParameterLoadStart(ParameterLoadStart), .Busy(Busy), .LoadDone(LoadDone),
    .LoadError(LoadError), .RetryCount(RetryCount), .LoadStatusCount(LoadStatusCount)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, $signed(act), $signed(exp));
    end
  endtask

  // Timeline model: cycle 1 is the first cycle after the request is accepted.
  int   plan[2][3];
  int   m_nst, m_nrise, m_done, m_fall, m_retry, m_status;
  int   m_st[8];
  logic m_sel[8];
  int   m_rise[8];
  logic m_err;

  task automatic model_load(input logic [1:0] mode, input logic cre);
    int em, passes, nxt, s, k, n;
    bit ok;
    em      = (mode == 2'd3) ? 0 : int'(mode);
    passes  = (em == 2) ? 2 : 1;
    m_nst   = 0; m_nrise = 0; m_done = -1; m_err = 1'b0; m_retry = 0; n = 0;
    nxt     = (cre ? 16 : 0) + 1 + 8 + 1;
    for (int p = 0; p < passes; p++) begin
      ok = 1'b0;
      for (int t = 0; t <= MR && !ok; t++) begin
        s = nxt;
        m_st[m_nst]  = s;
        m_sel[m_nst] = (p == 0) ? (em != 1) : 1'b0;
        m_nst++;
        m_retry = t;
        k = plan[p][t];
        if (k >= 1 && k <= T - 3) begin
          m_rise[m_nrise] = s + k;
          m_nrise++;
          ok = 1'b1;
          n  = s + k + 3 + 1;
        end else begin
          nxt = s + T + 1;
        end
      end
      if (!ok) begin
        m_err  = 1'b1;
        m_fall = nxt + 1;
        return;
      end
      if (p + 1 < passes) nxt = n + 10;
      else begin
        m_done = n + 1;
        m_fall = n + 2;
      end
    end
  endtask

  task automatic run_load(input string tag, input logic [1:0] mode, input logic cre,
                          input logic spur, input logic breq, input bit has_exp,
                          input logic e_ok, input logic e_err, input logic [1:0] e_rty);
    int nst, rst_n, rst_first, ld_n, ld_c, fall, spur_c, limit;
    int   st_c[8];
    logic st_s[8];
    logic err_c1, pld;
    model_load(mode, cre);
    nst = 0; rst_n = 0; rst_first = -1; ld_n = 0; ld_c = -1; fall = -1; err_c1 = 1'b0;
    spur_c = spur ? m_st[0] - 9 : -100;
    limit  = m_fall + 4;
    @(negedge Clk);
    LoadRequest = 1'b1; LoadMode = mode; ChipResetEnable = cre; ParameterLoadDone = 1'b0;
    for (int c = 1; c <= limit; c++) begin
      @(negedge Clk);
      if (ParameterLoadStart) begin
        if (nst < 8) begin st_c[nst] = c; st_s[nst] = SlowControlOrReadScopeSelect; end
        nst++;
      end
      if (MicrorocReset) begin if (rst_first < 0) rst_first = c; rst_n++; end
      if (LoadDone) begin ld_n++; if (ld_c < 0) ld_c = c; end
      if (!Busy && fall < 0) fall = c;
      if (c == 1) err_c1 = LoadError;
      LoadRequest = breq && (c == 3);
      if (breq && c == 3) LoadMode = ~mode;
      pld = 1'b0;
      for (int i = 0; i < m_nrise; i++) if (c >= m_rise[i] && c < m_rise[i] + 3) pld = 1'b1;
      if (c >= spur_c && c < spur_c + 3) pld = 1'b1;
      ParameterLoadDone = pld;
    end
    chk($sformatf("%s starts", tag), nst, m_nst);
    for (int i = 0; i < m_nst && i < nst; i++) begin
      chk($sformatf("%s start%0d cycle", tag, i), st_c[i], m_st[i]);
      chk($sformatf("%s start%0d select", tag, i), 32'(st_s[i]), 32'(m_sel[i]));
    end
    chk($sformatf("%s reset width", tag), rst_n, cre ? 16 : 0);
    chk($sformatf("%s reset first", tag), rst_first, cre ? 1 : -1);
    chk($sformatf("%s loaddone pulses", tag), ld_n, m_err ? 0 : 1);
    chk($sformatf("%s loaddone cycle", tag), ld_c, m_done);
    chk($sformatf("%s busy fall", tag), fall, m_fall);
    chk($sformatf("%s error cleared on accept", tag), 32'(err_c1), 0);
    chk($sformatf("%s error", tag), 32'(LoadError), 32'(m_err));
    chk($sformatf("%s retry", tag), 32'(RetryCount), m_retry);
    chk($sformatf("%s idle select", tag), 32'(SlowControlOrReadScopeSelect), 1);
    if (!m_err && m_status < 65535) m_status++;
`ifdef SEQ_LOAD_STATUS_COUNTER_EN
    chk($sformatf("%s status count", tag), 32'(LoadStatusCount), m_status);
`else
    chk($sformatf("%s status count", tag), 32'(LoadStatusCount), 0);
`endif
    if (has_exp) begin
      chk($sformatf("%s row ok", tag), 32'(ld_n != 0), 32'(e_ok));
      chk($sformatf("%s row err", tag), 32'(LoadError), 32'(e_err));
      chk($sformatf("%s row retry", tag), 32'(RetryCount), 32'(e_rty));
    end
  endtask

  typedef struct packed {
    logic [1:0] mode;
    logic       cre;
    logic       spur;
    logic       breq;
    int         k00, k01, k02, k10, k11, k12;
    logic       e_ok;
    logic       e_err;
    logic [1:0] e_rty;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int ab, nst, ld_n, late_bad;
    logic sel1;
    vecs[0] = '{mode:2'd0, cre:1'b1, spur:1'b0, breq:1'b0, k00:30, k01:-1, k02:-1, k10:-1, k11:-1, k12:-1, e_ok:1'b1, e_err:1'b0, e_rty:2'd0};
    vecs[1] = '{mode:2'd2, cre:1'b0, spur:1'b0, breq:1'b0, k00:20, k01:-1, k02:-1, k10:25, k11:-1, k12:-1, e_ok:1'b1, e_err:1'b0, e_rty:2'd0};
    vecs[2] = '{mode:2'd0, cre:1'b0, spur:1'b0, breq:1'b0, k00:47, k01:-1, k02:-1, k10:-1, k11:-1, k12:-1, e_ok:1'b1, e_err:1'b0, e_rty:2'd0};
    vecs[3] = '{mode:2'd1, cre:1'b0, spur:1'b0, breq:1'b0, k00:10, k01:-1, k02:-1, k10:-1, k11:-1, k12:-1, e_ok:1'b1, e_err:1'b0, e_rty:2'd0};
    vecs[4] = '{mode:2'd3, cre:1'b1, spur:1'b0, breq:1'b0, k00:-1, k01:15, k02:-1, k10:-1, k11:-1, k12:-1, e_ok:1'b1, e_err:1'b0, e_rty:2'd1};
    vecs[5] = '{mode:2'd2, cre:1'b0, spur:1'b0, breq:1'b0, k00:-1, k01:-1, k02:5,  k10:-1, k11:12, k12:-1, e_ok:1'b1, e_err:1'b0, e_rty:2'd1};
    vecs[6] = '{mode:2'd0, cre:1'b0, spur:1'b1, breq:1'b1, k00:1,  k01:-1, k02:-1, k10:-1, k11:-1, k12:-1, e_ok:1'b1, e_err:1'b0, e_rty:2'd0};
    vecs[7] = '{mode:2'd2, cre:1'b1, spur:1'b0, breq:1'b0, k00:46, k01:-1, k02:-1, k10:-1, k11:-1, k12:-1, e_ok:1'b0, e_err:1'b1, e_rty:2'd2};
    vecs[8] = '{mode:2'd0, cre:1'b0, spur:1'b0, breq:1'b0, k00:-1, k01:-1, k02:-1, k10:-1, k11:-1, k12:-1, e_ok:1'b0, e_err:1'b1, e_rty:2'd2};

    Reset = 1'b1; LoadRequest = 1'b0; LoadMode = 2'd0; ChipResetEnable = 1'b0;
    Abort = 1'b0; ParameterLoadDone = 1'b0; m_status = 0;
    repeat (3) @(negedge Clk);
    chk("reset MicrorocReset", 32'(MicrorocReset), 0);
    chk("reset Select", 32'(SlowControlOrReadScopeSelect), 1);
    chk("reset Start", 32'(ParameterLoadStart), 0);
    chk("reset Busy", 32'(Busy), 0);
    chk("reset LoadDone", 32'(LoadDone), 0);
    chk("reset LoadError", 32'(LoadError), 0);
    chk("reset RetryCount", 32'(RetryCount), 0);
    chk("reset StatusCount", 32'(LoadStatusCount), 0);
    Reset = 1'b0;

    for (int r = 0; r < 9; r++) begin
      plan[0][0] = vecs[r].k00; plan[0][1] = vecs[r].k01; plan[0][2] = vecs[r].k02;
      plan[1][0] = vecs[r].k10; plan[1][1] = vecs[r].k11; plan[1][2] = vecs[r].k12;
      run_load($sformatf("row%0d", r), vecs[r].mode, vecs[r].cre, vecs[r].spur, vecs[r].breq,
               1'b1, vecs[r].e_ok, vecs[r].e_err, vecs[r].e_rty);
    end

    // Reset in the middle of the chip reset pulse, right after a failed load.
    chk("sticky error in idle", 32'(LoadError), 1);
    @(negedge Clk);
    LoadRequest = 1'b1; LoadMode = 2'd0; ChipResetEnable = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(negedge Clk);
      LoadRequest = 1'b0;
      if (c == 5) begin
        chk("midreset MicrorocReset before", 32'(MicrorocReset), 1);
        Reset = 1'b1;
      end
      if (c == 6) begin
        chk("midreset MicrorocReset", 32'(MicrorocReset), 0);
        chk("midreset Select", 32'(SlowControlOrReadScopeSelect), 1);
        chk("midreset Busy", 32'(Busy), 0);
        chk("midreset Start", 32'(ParameterLoadStart), 0);
        chk("midreset LoadDone", 32'(LoadDone), 0);
        chk("midreset LoadError", 32'(LoadError), 0);
        chk("midreset RetryCount", 32'(RetryCount), 0);
        chk("midreset StatusCount", 32'(LoadStatusCount), 0);
        Reset = 1'b0;
        m_status = 0;
      end
    end

    // Abort in pass 1 wait of a two-pass load, then a late done must be ignored.
    plan[0][0] = 20; plan[0][1] = -1; plan[0][2] = -1;
    plan[1][0] = -1; plan[1][1] = -1; plan[1][2] = -1;
    model_load(2'd2, 1'b0);
    ab = m_st[1] + 5; nst = 0; ld_n = 0; late_bad = 0; sel1 = 1'b1;
    @(negedge Clk);
    LoadRequest = 1'b1; LoadMode = 2'd2; ChipResetEnable = 1'b0;
    for (int c = 1; c <= ab + 16; c++) begin
      @(negedge Clk);
      if (ParameterLoadStart) begin
        if (nst == 1) sel1 = SlowControlOrReadScopeSelect;
        nst++;
      end
      if (LoadDone) ld_n++;
      if (c == ab + 1) begin
        chk("abort Busy", 32'(Busy), 0);
        chk("abort Select", 32'(SlowControlOrReadScopeSelect), 1);
        chk("abort MicrorocReset", 32'(MicrorocReset), 0);
        chk("abort LoadError", 32'(LoadError), 0);
      end
      if (c > ab + 1 && (Busy || LoadDone)) late_bad++;
      LoadRequest = 1'b0;
      Abort = (c == ab);
      ParameterLoadDone = (c >= m_rise[0] && c < m_rise[0] + 3) || (c >= ab + 3 && c < ab + 6);
    end
    chk("abort starts", nst, 2);
    chk("abort pass1 select", 32'(sel1), 0);
    chk("abort no LoadDone", ld_n, 0);
    chk("abort late done ignored", late_bad, 0);

    plan[0][0] = 12; plan[0][1] = -1; plan[0][2] = -1;
    plan[1][0] = 18; plan[1][1] = -1; plan[1][2] = -1;
    run_load("after_abort", 2'd2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'd0);

    for (int r = 0; r < 12; r++) begin
      for (int p = 0; p < 2; p++)
        for (int t = 0; t < 3; t++)
          plan[p][t] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, T - 3));
      run_load($sformatf("rand%0d", r), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b0, 2'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time bound expired, got running, expected finished");
    $fatal(1);
  end

endmodule
